div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Iterative sequencer for RV32M DIV/DIVU/REM/REMU, used by the EX stage.
- Latches operands and runs a radix-2 restoring shift-subtract over DATA_W cycles.
- Handles divide-by-zero and signed overflow in fixed cycles.
- Drives the EX stall request so the pipeline holds until the result is ready.

Parameters:
DATA_W, 32, operand/result width (equals RegBus width)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
start_i  in  1  EX has a divide op this cycle; held high while stall_req_o is high
signed_i  in  1  1 = DIV/REM (signed), 0 = DIVU/REMU
rem_i  in  1  1 = return remainder, 0 = return quotient
dividend_i  in  DATA_W  r1 operand
divisor_i  in  DATA_W  r2 operand
cancel_i  in  1  pipeline flush; abort current operation
result_o  out  DATA_W  quotient or remainder; valid only when ready_o = 1
ready_o  out  1  one-cycle result-valid pulse
busy_o  out  1  state != IDLE
stall_req_o  out  1  combinational request for EX to hold the pipeline

Behaviour:
- Reset (rst = 0 at a clk edge), in any state: state = IDLE, counter = 0, all internal registers = 0. Outputs after reset: result_o = 0, ready_o = 0, busy_o = 0. stall_req_o = 0 while rst = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start_i = 1 and cancel_i = 0: latch signed_i, rem_i, abs(dividend), abs(divisor), quotient-negate flag (signed and signs differ) and remainder-negate flag (signed and dividend negative).
  - If divisor = 0: next state DONE, q = all ones, r = dividend (unmodified).
  - Else if signed, dividend = 0x80000000 and divisor = all ones: next state DONE, q = 0x80000000, r = 0.
  - Otherwise: next state CALC, counter = 0.
- CALC: one quotient bit per cycle.
  - Partial remainder is DATA_W+1 bits: shift left, bring in the next dividend MSB, subtract the divisor.
  - If the difference is non-negative, keep it and set the q bit to 1; otherwise keep the old value and set the q bit to 0.
  - Counter increments each cycle. After DATA_W cycles (counter == DATA_W-1 at the edge), go to DONE with signs applied: q = negate ? -q : q, same for r.
- DONE: ready_o = 1, result_o = rem_i ? r : q. Next state IDLE unconditionally; start_i is ignored in DONE.
- result_o holds its last value outside DONE; ready_o = 0 outside DONE.
- stall_req_o = (IDLE and start_i and !cancel_i) or CALC. It is 0 in DONE, so the pipeline advances the same cycle the result is presented.
- Latency from the start_i cycle:
  - normal op: ready_o at cycle DATA_W+1 (33 for DATA_W = 32);
  - zero-divisor or overflow: ready_o at cycle 1.
- cancel_i: has priority over start_i. In CALC or DONE, next state is IDLE with no ready_o pulse. A DONE-state pulse already presented this cycle is still output.
- Back-to-back ops: a new start_i is accepted in the IDLE cycle immediately after DONE.
- Arithmetic: abs() of 0x80000000 is 0x80000000, interpreted unsigned; all arithmetic is modulo 2^DATA_W.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if abs(dividend) < abs(divisor) (after the zero and overflow checks), go directly to DONE with q = 0 and r = dividend (original, signed). ready_o then arrives at cycle 1.
- Undefined: these ops take the full DATA_W-cycle CALC path and produce an identical result.

Decomposition:
- Shared package div_defs:
  - state encoding (IDLE, CALC, DONE);
  - DIV_CNT_W = clog2(DATA_W);
  - constants DIV_ZERO_Q (all ones) and SIGNED_MIN (0x80000000).
- Sub-module div_step: combinational single-iteration datapath.
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: next partial remainder, quotient bit.
  - div_ctrl keeps the FSM, counter, operand registers and sign fix-up.

Test Plan:
- DIVU 100 / 7, rem_i = 0: stall_req_o high cycles 0-32; ready_o at cycle 33 with result_o = 14. Repeat with rem_i = 1: result_o = 2.
- DIV signed -7 / 2: q = 0xFFFFFFFD (-3). REM -7 / 2: r = 0xFFFFFFFF (-1). REM 7 / -2: r = 1.
- Divisor zero, 5 / 0: ready_o at cycle 1 with q = 0xFFFFFFFF; REMU gives r = 5. stall_req_o is high only in cycle 0.
- Signed overflow 0x80000000 / 0xFFFFFFFF: q = 0x80000000, REM gives 0, both at cycle 1. DIVU of the same operands takes the full path: q = 0, r = 0x80000000.
- cancel_i at cycle 10 of CALC: IDLE at cycle 11, no ready_o. A new start 20 / 4 in cycle 12 gives 5 at cycle 45.
- rst = 0 at cycle 15 of CALC: next cycle busy_o = 0, stall_req_o = 0, ready_o = 0, result_o = 0.
- With DIV_EARLY_OUT_EN: 3 / 10 gives ready_o at cycle 1 with q = 0, r = 3. Without it: ready_o at cycle 33 with the same values.

Source files
------------

// File: rtl/div_defs.sv
`default_nettype none
// ============================================================================
//  Package : div_defs
//  Purpose : Shared definitions for the iterative RV32M divider: FSM state
//            encoding, counter-width helper and the architectural constants
//            for divide-by-zero and signed-overflow results.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package div_defs;

  // Reference operand width (RegBus width of the core).
  localparam int DIV_DATA_W = 32;

  // Width of the iteration counter for a given operand width.
  function automatic int div_cnt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_DATA_W);

  // Divide-by-zero quotient and the most negative signed value.
  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_Q = {DIV_DATA_W{1'b1}};
  localparam logic [DIV_DATA_W-1:0] SIGNED_MIN = {1'b1, {(DIV_DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage : div_defs
`default_nettype wire

// File: rtl/div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface : div_ctrl_if
//  Purpose   : Request/response bundle between the EX stage (master) and the
//              iterative divider (slave).
//  Signals   : start_i, signed_i, rem_i, dividend_i, divisor_i, cancel_i
//              (EX -> divider); result_o, ready_o, busy_o, stall_req_o
//              (divider -> EX).
//  Rev       : 1.0  initial release
// ============================================================================
interface div_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic              signed_i;
  logic              rem_i;
  logic [DATA_W-1:0] dividend_i;
  logic [DATA_W-1:0] divisor_i;
  logic              cancel_i;
  logic [DATA_W-1:0] result_o;
  logic              ready_o;
  logic              busy_o;
  logic              stall_req_o;

  modport master (
    output start_i, signed_i, rem_i, dividend_i, divisor_i, cancel_i,
    input  result_o, ready_o, busy_o, stall_req_o
  );

  modport slave (
    input  start_i, signed_i, rem_i, dividend_i, divisor_i, cancel_i,
    output result_o, ready_o, busy_o, stall_req_o
  );
endinterface : div_ctrl_if
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module  : div_step
//  Purpose : One radix-2 restoring division iteration (combinational).
//  Ports   : prem_i     partial remainder (DATA_W+1 bits)
//            dvd_msb_i  next dividend bit shifted into the remainder
//            divisor_i  unsigned divisor magnitude
//            prem_o     updated partial remainder
//            q_bit_o    quotient bit produced by this iteration
//  Rev     : 1.0  initial release
// ============================================================================
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   prem_i,
  input  logic              dvd_msb_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W:0]   prem_o,
  output logic              q_bit_o
);

  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] diff;

  // One extra bit beyond the shifted remainder so the sign of the
  // trial subtraction is exact.
  assign shifted = {prem_i, dvd_msb_i};
  assign diff    = shifted - {2'b00, divisor_i};

  assign q_bit_o = ~diff[DATA_W+1];
  assign prem_o  = q_bit_o ? diff[DATA_W:0] : shifted[DATA_W:0];

endmodule : div_step
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : div_ctrl
//  Purpose : Iterative sequencer for RV32M DIV/DIVU/REM/REMU in the EX stage.
//            Latches operand magnitudes, runs DATA_W restoring shift-subtract
//            iterations, applies sign fix-up, and requests an EX stall until
//            the result is presented. Divide-by-zero and signed overflow
//            complete in one cycle.
//  Ports   : clk          clock
//            rst          synchronous reset, active-low
//            bus (slave)  start_i/signed_i/rem_i/dividend_i/divisor_i/
//                         cancel_i in; result_o/ready_o/busy_o/stall_req_o out
//  Macro   : DIV_EARLY_OUT_EN - when defined, ops with |dividend| < |divisor|
//            finish in one cycle with q = 0, r = dividend.
//  Rev     : 1.0  initial release
// ============================================================================
module div_ctrl
  import div_defs::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  localparam int                CNT_W    = div_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

  div_state_e        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              rem_sel_q, rem_sel_d;
  logic              neg_q_q,   neg_q_d;
  logic              neg_r_q,   neg_r_d;
  logic [DATA_W-1:0] dvd_q,     dvd_d;
  logic [DATA_W-1:0] dvs_q,     dvs_d;
  logic [DATA_W:0]   prem_q,    prem_d;
  logic [DATA_W-1:0] result_q,  result_d;
  logic              ready_q,   ready_d;

  // Operand decode for the IDLE acceptance cycle.
  logic              dvd_neg, dvs_neg;
  logic [DATA_W-1:0] abs_dvd, abs_dvs;
  logic              div_zero, sgn_ovf, accept;

  assign dvd_neg  = bus.signed_i & bus.dividend_i[DATA_W-1];
  assign dvs_neg  = bus.signed_i & bus.divisor_i[DATA_W-1];
  // abs(MIN) wraps to MIN, which is the correct unsigned magnitude.
  assign abs_dvd  = dvd_neg ? -bus.dividend_i : bus.dividend_i;
  assign abs_dvs  = dvs_neg ? -bus.divisor_i  : bus.divisor_i;
  assign div_zero = (bus.divisor_i == '0);
  assign sgn_ovf  = bus.signed_i & (bus.dividend_i == MIN_VAL) &
                    (bus.divisor_i == ALL_ONES);
  assign accept   = bus.start_i & ~bus.cancel_i;

`ifdef DIV_EARLY_OUT_EN
  logic is_small;
  assign is_small = (abs_dvd < abs_dvs);
`endif

  // Iteration datapath. The dividend register doubles as the quotient
  // register: its MSB feeds the step while quotient bits enter at the LSB.
  logic [DATA_W:0]   prem_nx;
  logic              q_bit;
  logic [DATA_W-1:0] q_fin, r_fin, q_out, r_out;

  div_step #(.DATA_W(DATA_W)) u_step (
    .prem_i    (prem_q),
    .dvd_msb_i (dvd_q[DATA_W-1]),
    .divisor_i (dvs_q),
    .prem_o    (prem_nx),
    .q_bit_o   (q_bit)
  );

  assign q_fin = {dvd_q[DATA_W-2:0], q_bit};
  assign r_fin = prem_nx[DATA_W-1:0];
  assign q_out = neg_q_q ? -q_fin : q_fin;
  assign r_out = neg_r_q ? -r_fin : r_fin;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    result_d  = result_q;
    ready_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_sel_d = bus.rem_i;
          neg_q_d   = dvd_neg ^ dvs_neg;
          neg_r_d   = dvd_neg;
          dvd_d     = abs_dvd;
          dvs_d     = abs_dvs;
          prem_d    = '0;
          cnt_d     = '0;
          if (div_zero) begin
            state_d  = ST_DONE;
            ready_d  = 1'b1;
            result_d = bus.rem_i ? bus.dividend_i : ALL_ONES;
          end else if (sgn_ovf) begin
            state_d  = ST_DONE;
            ready_d  = 1'b1;
            result_d = bus.rem_i ? '0 : MIN_VAL;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (is_small) begin
            state_d  = ST_DONE;
            ready_d  = 1'b1;
            result_d = bus.rem_i ? bus.dividend_i : '0;
          end
`endif
          else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (bus.cancel_i) begin
          state_d = ST_IDLE;
        end else begin
          prem_d = prem_nx;
          dvd_d  = q_fin;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_DONE;
            ready_d  = 1'b1;
            result_d = rem_sel_q ? r_out : q_out;
          end
        end
      end

      // The result is presented this cycle; start_i is ignored here and a
      // cancel simply lands in IDLE like the normal path.
      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      prem_q    <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      prem_q    <= prem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o    = result_q;
  assign bus.ready_o     = ready_q;
  assign bus.busy_o      = (state_q != ST_IDLE);
  // Dropped in DONE so the pipeline advances while the result is presented.
  assign bus.stall_req_o = rst & ((state_q == ST_IDLE & accept) |
                                  (state_q == ST_CALC));

endmodule : div_ctrl
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_div_ctrl
//  Purpose : Self-checking bench for div_ctrl: a table of directed divide
//            vectors with hand-computed results and latencies, plus directed
//            sequences for cancel, reset during CALC and cancel in DONE.
//  Macro   : DIV_EARLY_OUT_EN changes the expected latency of small-dividend
//            vectors from 33 to 1 cycle.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_div_ctrl;
  import div_defs::*;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  logic clk;
  logic rst;

  div_ctrl_if #(.DATA_W(32)) bus ();

  div_ctrl #(.DATA_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          sgn;
    bit          rem;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  // Starts an op in the next cycle (cycle 0) and follows it to ready_o.
  task automatic run_op(input int idx, input bit sgn, input bit rem,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int cyc, stall_cnt, got_lat;
    bit seen;
    logic [31:0] res;
    logic stall_at_rdy;
    @(posedge clk); #1;
    bus.start_i    = 1'b1;
    bus.signed_i   = sgn;
    bus.rem_i      = rem;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.cancel_i   = 1'b0;
    #1;
    chk($sformatf("vec%0d idle ready", idx), {31'd0, bus.ready_o}, 32'd0);
    chk($sformatf("vec%0d idle busy", idx), {31'd0, bus.busy_o}, 32'd0);
    cyc = 0; stall_cnt = 0; seen = 0; got_lat = -1;
    res = '0; stall_at_rdy = 1'b0;
    while (!seen && cyc < 60) begin
      if (bus.ready_o) begin
        seen = 1; got_lat = cyc; res = bus.result_o;
        stall_at_rdy = bus.stall_req_o;
        bus.start_i = 1'b0;
      end else begin
        if (bus.stall_req_o) stall_cnt++;
        @(posedge clk); #2;
        cyc++;
      end
    end
    chk($sformatf("vec%0d latency", idx), got_lat, lat);
    chk($sformatf("vec%0d result", idx), res, exp);
    chk($sformatf("vec%0d stall cycles", idx), stall_cnt, lat);
    chk($sformatf("vec%0d stall at ready", idx), {31'd0, stall_at_rdy}, 32'd0);
  endtask

  initial begin
    int rdy_seen;

    vecs[0]  = '{0, 0, 32'd100,      32'd7,          32'd14,         33};
    vecs[1]  = '{0, 1, 32'd100,      32'd7,          32'd2,          33};
    vecs[2]  = '{1, 0, -32'sd7,      32'd2,          32'hFFFFFFFD,   33};
    vecs[3]  = '{1, 1, -32'sd7,      32'd2,          32'hFFFFFFFF,   33};
    vecs[4]  = '{1, 1, 32'd7,        -32'sd2,        32'd1,          33};
    vecs[5]  = '{1, 0, -32'sd7,      -32'sd2,        32'd3,          33};
    vecs[6]  = '{0, 0, 32'd5,        32'd0,          DIV_ZERO_Q,     1};
    vecs[7]  = '{0, 1, 32'd5,        32'd0,          32'd5,          1};
    vecs[8]  = '{1, 1, -32'sd5,      32'd0,          32'hFFFFFFFB,   1};
    vecs[9]  = '{1, 0, SIGNED_MIN,   32'hFFFFFFFF,   SIGNED_MIN,     1};
    vecs[10] = '{1, 1, SIGNED_MIN,   32'hFFFFFFFF,   32'd0,          1};
    vecs[11] = '{0, 0, SIGNED_MIN,   32'hFFFFFFFF,   32'd0,          EO_LAT};
    vecs[12] = '{0, 1, SIGNED_MIN,   32'hFFFFFFFF,   SIGNED_MIN,     EO_LAT};
    vecs[13] = '{0, 0, 32'd3,        32'd10,         32'd0,          EO_LAT};
    vecs[14] = '{0, 1, 32'd3,        32'd10,         32'd3,          EO_LAT};
    vecs[15] = '{1, 1, -32'sd3,      32'd10,         32'hFFFFFFFD,   EO_LAT};
    vecs[16] = '{1, 0, SIGNED_MIN,   32'd3,          32'hD5555556,   33};
    vecs[17] = '{1, 1, SIGNED_MIN,   32'd3,          32'hFFFFFFFE,   33};
    vecs[18] = '{0, 0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   33};
    vecs[19] = '{0, 0, 32'd0,        32'd5,          32'd0,          EO_LAT};

    // Reset with a pending request: stall must stay low while rst = 0.
    rst = 1'b0;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.rem_i = 1'b0;
    bus.dividend_i = 32'd9; bus.divisor_i = 32'd3; bus.cancel_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset result", bus.result_o, 32'd0);
    chk("reset ready", {31'd0, bus.ready_o}, 32'd0);
    chk("reset busy", {31'd0, bus.busy_o}, 32'd0);
    chk("reset stall", {31'd0, bus.stall_req_o}, 32'd0);
    bus.start_i = 1'b0;
    rst = 1'b1;

    // Back-to-back: each op starts in the IDLE cycle right after DONE.
    for (int i = 0; i < 20; i++)
      run_op(i, vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Start with cancel in IDLE: request ignored, no stall.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.cancel_i = 1'b1;
    bus.signed_i = 1'b0; bus.rem_i = 1'b0;
    bus.dividend_i = 32'd50; bus.divisor_i = 32'd5;
    #1;
    chk("idle cancel stall", {31'd0, bus.stall_req_o}, 32'd0);
    @(posedge clk); #2;
    chk("idle cancel busy", {31'd0, bus.busy_o}, 32'd0);
    bus.start_i = 1'b0; bus.cancel_i = 1'b0;

    // Cancel in cycle 10 of a long op, then 20 / 4 started in cycle 12.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    rdy_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #2;
      if (bus.ready_o) rdy_seen++;
    end
    bus.cancel_i = 1'b1;
    @(posedge clk); #2;
    if (bus.ready_o) rdy_seen++;
    chk("cancel busy c11", {31'd0, bus.busy_o}, 32'd0);
    chk("cancel stall c11", {31'd0, bus.stall_req_o}, 32'd0);
    bus.cancel_i = 1'b0; bus.start_i = 1'b0;
    chk("cancel no ready", rdy_seen, 0);
    run_op(100, 1'b0, 1'b0, 32'd20, 32'd4, 32'd5, 33);

    // Reset asserted in cycle 15 of CALC.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #2;
    end
    chk("calc busy c15", {31'd0, bus.busy_o}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("rst busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst stall", {31'd0, bus.stall_req_o}, 32'd0);
    chk("rst ready", {31'd0, bus.ready_o}, 32'd0);
    chk("rst result", bus.result_o, 32'd0);
    bus.start_i = 1'b0;
    rst = 1'b1;

    // Cancel while DONE: pulse still presented, then back to IDLE.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.rem_i = 1'b0;
    bus.dividend_i = 32'd5; bus.divisor_i = 32'd0;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.cancel_i = 1'b1;
    #1;
    chk("done cancel ready", {31'd0, bus.ready_o}, 32'd1);
    chk("done cancel result", bus.result_o, 32'hFFFFFFFF);
    @(posedge clk); #2;
    chk("done cancel busy", {31'd0, bus.busy_o}, 32'd0);
    chk("done cancel ready off", {31'd0, bus.ready_o}, 32'd0);
    bus.cancel_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_ctrl
`default_nettype wire
